uart_program_loader: RTL and testbench

//  Sits between uart_rx and the CPU instruction memory. Waits for a sync byte, then packs

---
 rtl/loader_pkg.sv | 14 +
 rtl/uart_program_loader_if.sv | 27 ++
 rtl/uart_program_loader_word_packer.sv | 31 +++
 rtl/uart_program_loader.sv | 155 +++++++++++++++
 tb/tb_uart_program_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the UART program loader
package loader_pkg;

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_LOAD  = 2'd1,
        L_CKSUM = 2'd2,
        L_DONE  = 2'd3
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hAA;
    localparam logic [31:0] TERM_WORD     = 32'h0000_0000;

endpackage

// File: rtl/uart_program_loader_if.sv
// rtl/uart_program_loader_if.sv - byte input and instruction-memory write port bundle
interface uart_program_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    // Byte source side (uart_rx / testbench)
    modport master (
        output rx_data, rx_valid, rx_ferr,
        input  wr_en, wr_addr, wr_data, load_busy, load_done, load_err, word_count
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid, rx_ferr,
        output wr_en, wr_addr, wr_data, load_busy, load_done, load_err, word_count
    );
endinterface

// File: rtl/uart_program_loader_word_packer.sv
// rtl/uart_program_loader_word_packer.sv - big-endian byte-to-word packer
module word_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    logic [1:0]  r_byte_idx;
    logic [31:0] r_shift;
    logic [31:0] w_word;

    // The word completes combinationally with the 4th byte so the owner can
    // register the memory write on that same edge.
    assign w_word       = {r_shift[23:0], i_byte};
    assign o_word       = w_word;
    assign o_word_valid = i_valid && (r_byte_idx == 2'd3);

    // Shift bytes in MSB-first and track position within the word
    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            r_byte_idx <= 2'd0;
            r_shift    <= 32'h0;
        end else if (i_valid) begin
            r_shift    <= w_word;
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end
endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - sync-armed UART image loader into instruction memory (option: LOADER_CKSUM_EN)
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input logic                  clk,
    input logic                  rstn,
    uart_program_loader_if.slave bus
);
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_load_busy;
    logic              r_load_done;
    logic              r_load_err;
    logic [ADDR_W:0]   r_word_count;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_done_pend;
`ifdef LOADER_CKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_byte_ok;
    logic              w_ferr;
    logic              w_pk_valid;
    logic              w_pk_clear;
    logic              w_word_valid;
    logic [31:0]       w_word;

    assign w_byte_ok  = bus.rx_valid && !bus.rx_ferr;
    assign w_ferr     = bus.rx_valid && bus.rx_ferr;
    assign w_pk_valid = (r_state == L_LOAD) && w_byte_ok;
    // Holding the packer clear while idle discards any partial word after an abort
    assign w_pk_clear = (r_state == L_IDLE);

    word_packer u_packer (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (w_pk_clear),
        .i_valid      (w_pk_valid),
        .i_byte       (bus.rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.load_busy  = r_load_busy;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;
    assign bus.word_count = r_word_count;

    // Loader FSM: arm on sync, write packed words, stop on terminator or error
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= L_IDLE;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 32'h0;
            r_load_busy  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_word_count <= '0;
            r_ptr        <= '0;
            r_done_pend  <= 1'b0;
`ifdef LOADER_CKSUM_EN
            r_xor        <= 8'h0;
`endif
        end else begin
            r_wr_en     <= 1'b0;
            r_load_done <= r_done_pend;
            r_done_pend <= 1'b0;
            case (r_state)
                L_IDLE: begin
                    if (w_byte_ok && (bus.rx_data == SYNC_BYTE)) begin
                        r_state      <= L_LOAD;
                        r_load_busy  <= 1'b1;
                        r_load_err   <= 1'b0;
                        r_word_count <= '0;
                        r_ptr        <= '0;
`ifdef LOADER_CKSUM_EN
                        r_xor        <= 8'h0;
`endif
                    end
                end
                L_LOAD: begin
                    if (w_ferr) begin
                        r_state     <= L_IDLE;
                        r_load_busy <= 1'b0;
                        r_load_err  <= 1'b1;
                    end else if (w_byte_ok) begin
`ifdef LOADER_CKSUM_EN
                        r_xor <= r_xor ^ bus.rx_data;
`endif
                        if (w_word_valid) begin
                            // The last slot is kept for the terminator only
                            if ((w_word != TERM_WORD) && (r_ptr == PTR_LAST)) begin
                                r_state     <= L_IDLE;
                                r_load_busy <= 1'b0;
                                r_load_err  <= 1'b1;
                            end else begin
                                r_wr_en      <= 1'b1;
                                r_wr_addr    <= r_ptr;
                                r_wr_data    <= w_word;
                                r_ptr        <= r_ptr + PTR_ONE;
                                r_word_count <= r_word_count + CNT_ONE;
                                if (w_word == TERM_WORD) begin
`ifdef LOADER_CKSUM_EN
                                    r_state     <= L_CKSUM;
`else
                                    r_state     <= L_DONE;
                                    r_load_busy <= 1'b0;
                                    r_done_pend <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                end
                L_CKSUM: begin
`ifdef LOADER_CKSUM_EN
                    if (w_ferr) begin
                        r_state     <= L_IDLE;
                        r_load_busy <= 1'b0;
                        r_load_err  <= 1'b1;
                    end else if (w_byte_ok) begin
                        r_load_busy <= 1'b0;
                        if (bus.rx_data == r_xor) begin
                            r_state     <= L_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state    <= L_IDLE;
                            r_load_err <= 1'b1;
                        end
                    end
`else
                    r_state <= L_IDLE;
`endif
                end
                L_DONE: begin
                    r_state <= L_DONE;
                end
                default: r_state <= L_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - scoreboard bench for uart_program_loader (option: LOADER_CKSUM_EN)
module tb_uart_program_loader;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   cyc;

    uart_program_loader_if #(.ADDR_W(6)) bus_a ();
    uart_program_loader_if #(.ADDR_W(2)) bus_b ();

    uart_program_loader #(.ADDR_W(6)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    uart_program_loader #(.ADDR_W(2)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

    logic [37:0] q_a[$];
    logic [33:0] q_b[$];
    int          wr_cnt_a, wr_cnt_b, done_cnt_a, done_cnt_b, last_wr_cyc_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the 64-word instance
    always @(negedge clk) begin
        if (rstn && bus_a.wr_en) begin
            wr_cnt_a++;
            last_wr_cyc_a = cyc;
            if (q_a.size() == 0) check("a_unexpected_wr", {26'h0, bus_a.wr_addr, bus_a.wr_data}, 64'hdead);
            else check("a_wr", {26'h0, bus_a.wr_addr, bus_a.wr_data}, {26'h0, q_a.pop_front()});
        end
        if (rstn && bus_a.load_done) begin
            done_cnt_a++;
`ifndef LOADER_CKSUM_EN
            check("a_done_latency", cyc, last_wr_cyc_a + 1);
`endif
        end
    end

    // Scoreboard monitor for the 4-word instance
    always @(negedge clk) begin
        if (rstn && bus_b.wr_en) begin
            wr_cnt_b++;
            if (q_b.size() == 0) check("b_unexpected_wr", {30'h0, bus_b.wr_addr, bus_b.wr_data}, 64'hdead);
            else check("b_wr", {30'h0, bus_b.wr_addr, bus_b.wr_data}, {30'h0, q_b.pop_front()});
        end
        if (rstn && bus_b.load_done) done_cnt_b++;
    end

    task automatic send(input bit sel, input logic [7:0] b, input bit ferr);
        @(negedge clk);
        if (!sel) begin
            bus_a.rx_data = b; bus_a.rx_ferr = ferr; bus_a.rx_valid = 1'b1;
        end else begin
            bus_b.rx_data = b; bus_b.rx_ferr = ferr; bus_b.rx_valid = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_a.rx_valid = 1'b0; bus_a.rx_ferr = 1'b0;
            bus_b.rx_valid = 1'b0; bus_b.rx_ferr = 1'b0;
        end
    endtask

    task automatic send_g(input bit sel, input logic [7:0] b);
        send(sel, b, 1'b0);
        idle(1);
    endtask

    task automatic send_word_g(input bit sel, input logic [31:0] w);
        send_g(sel, w[31:24]); send_g(sel, w[23:16]); send_g(sel, w[15:8]); send_g(sel, w[7:0]);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        q_a.delete();
        q_b.delete();
    endtask

    task automatic wait_done_a(input int target, input string tag);
        for (int i = 0; i < 40 && done_cnt_a < target; i++) @(negedge clk);
        check(tag, done_cnt_a, target);
    endtask

    // Appends the checksum byte in the checksum build; nothing otherwise
    task automatic finish_image(input logic [7:0] x, input bit b2b);
`ifdef LOADER_CKSUM_EN
        if (b2b) send(1'b0, x, 1'b0); else send_g(1'b0, x);
`endif
    endtask

    int wr0, done0;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        wr_cnt_a = 0; wr_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0; last_wr_cyc_a = 0;
        bus_a.rx_data = 8'h0; bus_a.rx_valid = 1'b0; bus_a.rx_ferr = 1'b0;
        bus_b.rx_data = 8'h0; bus_b.rx_valid = 1'b0; bus_b.rx_ferr = 1'b0;
        rstn = 1'b0;

        do_reset();
        check("rst_wr_en", bus_a.wr_en, 0);
        check("rst_busy", bus_a.load_busy, 0);
        check("rst_done", bus_a.load_done, 0);
        check("rst_err", bus_a.load_err, 0);
        check("rst_wcount", bus_a.word_count, 0);
        check("rst_wr_addr", bus_a.wr_addr, 0);

        // Basic image: one word then terminator
        q_a.push_back({6'd0, 32'h2001_0005});
        q_a.push_back({6'd1, 32'h0});
        send_g(0, 8'hAA);
        check("t1_busy", bus_a.load_busy, 1);
        send_word_g(0, 32'h2001_0005);
        send_word_g(0, 32'h0);
        finish_image(8'h24, 1'b0);
        wait_done_a(1, "t1_done");
        idle(2);
        check("t1_wcount", bus_a.word_count, 2);
        check("t1_busy_after", bus_a.load_busy, 0);
        check("t1_wr_total", wr_cnt_a, 2);

        // Noise before sync is ignored
        do_reset();
        wr0 = wr_cnt_a; done0 = done_cnt_a;
        send_g(0, 8'h11); send_g(0, 8'h22);
        idle(3);
        check("t2_no_wr", wr_cnt_a, wr0);
        check("t2_idle", bus_a.load_busy, 0);
        q_a.push_back({6'd0, 32'h0102_0304});
        q_a.push_back({6'd1, 32'h0});
        send_g(0, 8'hAA);
        send_word_g(0, 32'h0102_0304);
        send_word_g(0, 32'h0);
        finish_image(8'h04, 1'b0);
        wait_done_a(done0 + 1, "t2_done");
        check("t2_wr_total", wr_cnt_a, wr0 + 2);

        // Framing error aborts, next sync clears the flag
        do_reset();
        wr0 = wr_cnt_a;
        send_g(0, 8'hAA); send_g(0, 8'h01); send_g(0, 8'h02);
        send(0, 8'h03, 1'b1); idle(2);
        check("t3_err", bus_a.load_err, 1);
        check("t3_busy", bus_a.load_busy, 0);
        check("t3_no_wr", wr_cnt_a, wr0);
        send_g(0, 8'hAA); idle(1);
        check("t3_err_clr", bus_a.load_err, 0);
        check("t3_rearm", bus_a.load_busy, 1);

        // Capacity overflow on the 4-word instance
        do_reset();
        check("t4_rst_err", bus_a.load_err, 0);
        q_b.push_back({2'd0, 32'h1111_1111});
        q_b.push_back({2'd1, 32'h2222_2222});
        q_b.push_back({2'd2, 32'h3333_3333});
        send_g(1, 8'hAA);
        send_word_g(1, 32'h1111_1111);
        send_word_g(1, 32'h2222_2222);
        send_word_g(1, 32'h3333_3333);
        send_word_g(1, 32'h4444_4444);
        idle(3);
        check("t4_err", bus_b.load_err, 1);
        check("t4_wcount", bus_b.word_count, 3);
        check("t4_wr_total", wr_cnt_b, 3);
        check("t4_no_done", done_cnt_b, 0);
        check("t4_busy", bus_b.load_busy, 0);

        // Back-to-back bytes, then traffic after DONE is ignored
        do_reset();
        wr0 = wr_cnt_a; done0 = done_cnt_a;
        q_a.push_back({6'd0, 32'hAAAA_0102});
        q_a.push_back({6'd1, 32'h0});
        send(0, 8'hAA, 0);
        send(0, 8'hAA, 0); send(0, 8'hAA, 0); send(0, 8'h01, 0); send(0, 8'h02, 0);
        send(0, 8'h00, 0); send(0, 8'h00, 0); send(0, 8'h00, 0); send(0, 8'h00, 0);
        finish_image(8'h03, 1'b1);
        idle(1);
        wait_done_a(done0 + 1, "t5_done");
        check("t5_wr_total", wr_cnt_a, wr0 + 2);
        send(0, 8'hAA, 0); send(0, 8'h05, 0); send(0, 8'h06, 0); send(0, 8'h07, 0); send(0, 8'h08, 0);
        idle(4);
        check("t5_ignored_wr", wr_cnt_a, wr0 + 2);
        check("t5_ignored_done", done_cnt_a, done0 + 1);
        check("t5_wcount_hold", bus_a.word_count, 2);

`ifdef LOADER_CKSUM_EN
        // Checksum accepted
        do_reset();
        done0 = done_cnt_a;
        q_a.push_back({6'd0, 32'h1234_5678});
        q_a.push_back({6'd1, 32'h0});
        send_g(0, 8'hAA);
        send_word_g(0, 32'h1234_5678);
        send_word_g(0, 32'h0);
        idle(1);
        check("t6_cksum_busy", bus_a.load_busy, 1);
        send_g(0, 8'h08);
        wait_done_a(done0 + 1, "t6_done");
        check("t6_err", bus_a.load_err, 0);

        // Checksum rejected
        do_reset();
        done0 = done_cnt_a;
        q_a.push_back({6'd0, 32'h1234_5678});
        q_a.push_back({6'd1, 32'h0});
        send_g(0, 8'hAA);
        send_word_g(0, 32'h1234_5678);
        send_word_g(0, 32'h0);
        send_g(0, 8'h09);
        idle(4);
        check("t6_bad_err", bus_a.load_err, 1);
        check("t6_bad_no_done", done_cnt_a, done0);
        check("t6_bad_busy", bus_a.load_busy, 0);
`endif

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
